// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the Y86-64 fetch stage: fetch address out,
// instruction bytes and address-error flag back.
interface fetch_unit_if;
    logic [63:0] f_pc;
    logic        imem_error;
    logic [7:0]  Byte0;
    logic [71:0] Byte19;

    modport master (output f_pc, input imem_error, Byte0, Byte19);
    modport slave  (input f_pc, output imem_error, Byte0, Byte19);
endinterface

// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: PC select, instruction split, valP/predPC, and the
// F (predPC) and D pipeline registers with stall/bubble control.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         F_stall,
    input  logic         D_stall,
    input  logic         D_bubble,
    input  logic [3:0]   M_icode,
    input  logic         M_Cnd,
    input  logic [63:0]  M_valA,
    input  logic [3:0]   W_icode,
    input  logic [63:0]  W_valM,
    fetch_unit_if.master imem,
    output logic [63:0]  f_predPC,
    output logic [2:0]   D_stat,
    output logic [3:0]   D_icode,
    output logic [3:0]   D_ifun,
    output logic [3:0]   D_rA,
    output logic [3:0]   D_rB,
    output logic [63:0]  D_valC,
    output logic [63:0]  D_valP
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    logic [63:0] pred_pc_q, pred_pc_d;
    stat_e       stat_q, stat_d;
    logic [3:0]  icode_q, icode_d, ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d, rb_q, rb_d;
    logic [63:0] valc_q, valc_d, valp_q, valp_d;

    logic [63:0] f_pc;
    logic [3:0]  f_icode, f_ifun, f_ra, f_rb;
    logic [63:0] f_valc, f_valp;
    logic        f_valid, need_regids, need_valc;
    stat_e       f_stat;

    // Mispredicted branch in M outranks a returning ret in W.
    always_comb begin
        if (M_icode == 4'h7 && !M_Cnd)
            f_pc = M_valA;
        else if (W_icode == 4'h9)
            f_pc = W_valM;
        else
            f_pc = pred_pc_q;
    end

    assign imem.f_pc = f_pc;

    always_comb begin
        f_icode = imem.imem_error ? 4'h1 : imem.Byte0[7:4];
        f_ifun  = imem.imem_error ? 4'h0 : imem.Byte0[3:0];

        case (f_icode)
            4'h2, 4'h7: f_valid = (f_ifun <= 4'h6);
            4'h6:       f_valid = (f_ifun <= 4'h3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                        f_valid = (f_ifun == 4'h0);
            default:    f_valid = 1'b0;
        endcase

        case (f_icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = f_valid;
            default:                                 need_regids = 1'b0;
        endcase

        case (f_icode)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = f_valid;
            default:                     need_valc = 1'b0;
        endcase

        if (need_regids) begin
            f_ra   = imem.Byte19[7:4];
            f_rb   = imem.Byte19[3:0];
            f_valc = imem.Byte19[71:8];
        end else begin
            f_ra   = 4'hF;
            f_rb   = 4'hF;
            f_valc = imem.Byte19[63:0];
        end
        if (!need_valc)
            f_valc = '0;

        f_valp = f_pc + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'd0};

        if (f_icode == 4'h7 || f_icode == 4'h8)
            f_predPC = f_valc;
        else
            f_predPC = f_valp;

        if (imem.imem_error)
            f_stat = STAT_ADR;
        else if (!f_valid)
            f_stat = STAT_INS;
        else if (f_icode == 4'h0)
            f_stat = STAT_HLT;
        else
            f_stat = STAT_AOK;
    end

    always_comb begin
        pred_pc_d = F_stall ? pred_pc_q : f_predPC;

        stat_d  = stat_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        if (D_stall) begin
            // hold
        end else if (D_bubble) begin
            stat_d  = STAT_AOK;
            icode_d = 4'h1;
            ifun_d  = 4'h0;
            ra_d    = 4'hF;
            rb_d    = 4'hF;
            valc_d  = '0;
            valp_d  = '0;
        end else begin
            stat_d  = f_stat;
            icode_d = f_icode;
            ifun_d  = f_ifun;
            ra_d    = f_ra;
            rb_d    = f_rb;
            valc_d  = f_valc;
            valp_d  = f_valp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_pc_q <= RESET_PC;
            stat_q    <= STAT_AOK;
            icode_q   <= 4'h1;
            ifun_q    <= 4'h0;
            ra_q      <= 4'hF;
            rb_q      <= 4'hF;
            valc_q    <= '0;
            valp_q    <= '0;
        end else begin
            pred_pc_q <= pred_pc_d;
            stat_q    <= stat_d;
            icode_q   <= icode_d;
            ifun_q    <= ifun_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            valc_q    <= valc_d;
            valp_q    <= valp_d;
        end
    end

    assign D_stat  = stat_q;
    assign D_icode = icode_q;
    assign D_ifun  = ifun_q;
    assign D_rA    = ra_q;
    assign D_rB    = rb_q;
    assign D_valC  = valc_q;
    assign D_valP  = valp_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Y86-64 pipeline fetch stage wrapped around the instruction memory. Selects the fetch PC and drives it to the memory. Splits the returned bytes into icode/ifun/rA/rB/valC and computes valP and the predicted next PC. Holds the F (predPC) and D pipeline registers with stall and bubble control from the pipeline control logic.

## Interface
- RESET_PC, 64'd0, value loaded into the F predPC register on reset.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears F and D registers immediately.
- F_stall  in  1  hold the F register.
- D_stall  in  1  hold the D register.
- D_bubble  in  1  load a nop bubble into D.
- M_icode  in  4  icode in the M stage.
- M_Cnd  in  1  branch condition in the M stage.
- M_valA  in  64  fall-through PC of the M-stage jXX.
- W_icode  in  4  icode in the W stage.
- W_valM  in  64  return address read by the W-stage ret.
- imem_error  in  1  memory address error for f_pc.
- Byte0  in  8  byte at f_pc: {icode[7:4], ifun[3:0]}.
- Byte19  in  72  bytes f_pc+1..f_pc+9, little-endian; byte f_pc+1 is in [7:0].
- f_pc  out  64  fetch address to the instruction memory.
- f_predPC  out  64  predicted next PC (combinational).
- D_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- D_icode  out  4
- D_ifun  out  4
- D_rA  out  4
- D_rB  out  4
- D_valC  out  64
- D_valP  out  64

## Operation
- PC select, in priority order:
  - If M_icode==7 and !M_Cnd, f_pc=M_valA.
  - Else if W_icode==9, f_pc=W_valM.
  - Else f_pc=F_predPC.
- Field split:
  - On imem_error, icode=1 and ifun=0.
  - Otherwise icode and ifun come from Byte0.
- Instruction validity:
  - icode 0,1,3,4,5,8,9,A,B require ifun=0.
  - icode 2 and 7 accept ifun 0-6.
  - icode 6 accepts ifun 0-3.
  - Anything else is invalid.
- need_regids is set for icode 2,3,4,5,6,A,B.
- need_valC is set for icode 3,4,5,7,8.
- Registers and constant:
  - With need_regids: rA=Byte19[7:4], rB=Byte19[3:0], valC=Byte19[71:8].
  - Without need_regids: rA=rB=4'hF, valC=Byte19[63:0].
  - If need_valC=0, valC=0.
- valP = f_pc + 1 + need_regids + 8*need_valC, computed in 64 bits with wrap-around.
- Invalid instruction: need_regids=need_valC=0, so valP=f_pc+1.
- f_predPC = valC for icode 7 or 8; valP otherwise.
- stat, in priority order: imem_error gives ADR; invalid gives INS; icode 0 gives HLT; otherwise AOK.
- F register:
  - predPC loads f_predPC each edge unless F_stall.
  - Reset value is RESET_PC.
- D register, per edge:
  - D_stall holds the register; it has priority over D_bubble.
  - Else D_bubble loads the bubble.
  - Else the register loads the fetched fields.
- Bubble and reset value of D: stat=1, icode=1, ifun=0, rA=rB=4'hF, valC=0, valP=0.
- The block does not stop on HLT, ADR or INS. Freezing the pipeline is the control logic's job.

## Timing
- f_pc and f_predPC are combinational from the F register and the M/W inputs.
- Memory outputs are combinational on f_pc. The fields of the instruction at f_pc appear on D_* after the next rising edge (1-cycle latency).
- Reset asserted mid-operation clears F and D immediately, without waiting for clk. First fetch after release is at RESET_PC.
- Simultaneous M misprediction and W ret: the M path wins.
- Stall and bubble inputs are sampled only at the rising edge.

## Test plan
- Reset:
  - Assert reset, release it.
  - Required: f_pc=0; D_icode=1, D_ifun=0, D_rA=D_rB=F, D_valC=0, D_valP=0, D_stat=1.
- irmovq:
  - f_pc=1, Byte0=0x30, Byte19={64'h200,8'hF4}.
  - Required after the edge: D_icode=3, D_rA=F, D_rB=4, D_valC=0x200, D_valP=11, D_stat=1, f_pc=11.
- call and OPq:
  - f_pc=57, Byte0=0x80, Byte19[63:0]=0x70.
  - Required: f_predPC=0x70, D_valP=66.
  - Then OPq at f_pc=55 (Byte0=0x60, Byte19[7:0]=0xDC).
  - Required: D_rA=D, D_rB=C, D_valP=57.
- Redirects:
  - M_icode=7, M_Cnd=0, M_valA=0x9C, W_icode=9, W_valM=0x42.
  - Required: f_pc=0x9C in the same cycle.
  - Drop the M condition.
  - Required: f_pc=0x42.
- Exceptions:
  - imem_error=1.
  - Required: D_stat=3, D_icode=1.
  - Byte0=0xC0.
  - Required: D_stat=4, D_valP=f_pc+1.
  - Byte0=0x00.
  - Required: D_stat=2.
- Stall and bubble:
  - F_stall=D_stall=1 for 2 cycles.
  - Required: f_pc and D_* unchanged.
  - D_bubble=1 alone.
  - Required: D equals the bubble values.
  - D_stall=D_bubble=1.
  - Required: D holds.
